sub_32bit_pipe: RTL

//  Two-stage pipelined 32-bit subtractor: D = A - B, with borrow and N/Z/V flags.

---
 rtl/sub_32bit_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sub_32bit_pipe.sv
// sub_32bit_pipe: two-stage pipelined subtractor, D = A - B, computed as A + ~B + 1.
// Stage 1 adds the low half and registers the half-carry. Stage 2 is the output
// register: it adds the high half using that carry and registers D and the flags.
// Both ends use a valid/ready handshake. in_ready is combinational from out_ready
// because there is no skid buffer.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/B valid           in_ready   operands accepted this cycle
//   A, B       minuend, subtrahend
//   out_valid  result valid        out_ready  consumer accepts result
//   D          A - B mod 2^WIDTH
//   BO         borrow out (A < B unsigned)
//   N, Z, V    negative, zero and signed-overflow flags
module sub_32bit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned HALF  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             N,
    output logic             Z,
    output logic             V
);

    localparam int unsigned HW = WIDTH - HALF;

    // Stage 1 state
    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] s1_lo_q,    s1_lo_d;
    logic            s1_c_q,     s1_c_d;
    logic [HW-1:0]   s1_ahi_q,   s1_ahi_d;
    logic [HW-1:0]   s1_bhi_q,   s1_bhi_d;

    // Stage 2 (output) state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] d_q,  d_d;
    logic             bo_q, bo_d;
    logic             n_q,  n_d;
    logic             z_q,  z_d;
    logic             v_q,  v_d;

    logic            s2_free, s1_free, accept, s2_load;
    logic [HALF:0]   lo_sum;
    logic [HW:0]     hi_sum;
    logic [WIDTH-1:0] d_next;

    assign s2_free  = ~out_valid_q | out_ready;
    assign s1_free  = ~s1_valid_q | s2_free;
    assign in_ready = s1_free;
    assign accept   = in_valid & s1_free;
    assign s2_load  = s1_valid_q & s2_free;

    // Low half: A_lo + ~B_lo + 1; bit HALF is the carry into the high half.
    assign lo_sum = {1'b0, A[HALF-1:0]} + {1'b0, ~B[HALF-1:0]} + (HALF+1)'(1);
    // High half uses the registered half-carry instead of the +1.
    assign hi_sum = {1'b0, s1_ahi_q} + {1'b0, ~s1_bhi_q} + (HW+1)'(s1_c_q);
    assign d_next = {hi_sum[HW-1:0], s1_lo_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_c_d     = s1_c_q;
        s1_ahi_d   = s1_ahi_q;
        s1_bhi_d   = s1_bhi_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = lo_sum[HALF-1:0];
            s1_c_d     = lo_sum[HALF];
            s1_ahi_d   = A[WIDTH-1:HALF];
            s1_bhi_d   = B[WIDTH-1:HALF];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        d_d         = d_q;
        bo_d        = bo_q;
        n_d         = n_q;
        z_d         = z_q;
        v_d         = v_q;
        if (s2_load) begin
            // A handshake coinciding with an s1 advance keeps out_valid high.
            out_valid_d = 1'b1;
            d_d         = d_next;
            bo_d        = ~hi_sum[HW];
            n_d         = d_next[WIDTH-1];
            z_d         = (d_next == '0);
            v_d         = (s1_ahi_q[HW-1] ^ s1_bhi_q[HW-1]) & (s1_ahi_q[HW-1] ^ d_next[WIDTH-1]);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_c_q      <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bo_q        <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_c_q      <= s1_c_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            bo_q        <= bo_d;
            n_q         <= n_d;
            z_q         <= z_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign BO        = bo_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign V         = v_q;

endmodule
